// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared types and constants for the PS/2 receive path.
//            - ps2_state_e : receive FSM state encoding
//            - c_FRAME_LEN : bits per PS/2 frame (start + 8 data + parity + stop)
//            - c_DATA_W    : scan-code byte width
// Revision : 1.0  initial release
// ============================================================================
package ps2_pkg;

    localparam int c_FRAME_LEN = 11;
    localparam int c_DATA_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_line_filter
// Purpose  : Brings the raw PS/2 clock and data pins into the i_clk domain,
//            rejects glitches shorter than CLK_DIV_FILTER samples and flags
//            each falling edge of the cleaned PS/2 clock.
// Ports    : i_clk      system clock (rising edge)
//            i_rst_n    asynchronous active-low reset
//            i_ps2_clk  raw PS/2 clock pin
//            i_ps2_data raw PS/2 data pin
//            o_data     filtered PS/2 data level
//            o_fall     one-cycle strobe on filtered PS/2 clock 1->0
// Revision : 1.0  initial release
// ============================================================================
module ps2_line_filter #(
    parameter int CLK_DIV_FILTER = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_data,
    output logic o_fall
);

    localparam int                 c_CNT_W    = (CLK_DIV_FILTER > 1) ? $clog2(CLK_DIV_FILTER) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLK_DIV_FILTER - 1);

    // Bit 0 carries the PS/2 clock, bit 1 the PS/2 data.
    logic [1:0] w_raw;
    logic [1:0] meta_q;
    logic [1:0] sync_q;
    logic [1:0] w_filt;
    logic       clk_prev_q;

    assign w_raw = {i_ps2_data, i_ps2_clk};

    // Two-flop synchronizer; idle PS/2 lines are high so reset to 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= 2'b11;
            sync_q <= 2'b11;
        end else begin
            meta_q <= w_raw;
            sync_q <= meta_q;
        end
    end

    // Per-line filter: the level only moves once CLK_DIV_FILTER consecutive
    // samples disagree with it; any agreeing sample restarts the run.
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
        logic [c_CNT_W-1:0] cnt_q;
        logic               lvl_q;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                cnt_q <= '0;
                lvl_q <= 1'b1;
            end else if (sync_q[gi] != lvl_q) begin
                if (cnt_q == c_CNT_LAST) begin
                    lvl_q <= sync_q[gi];
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end

        assign w_filt[gi] = lvl_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_prev_q <= 1'b1;
        end else begin
            clk_prev_q <= w_filt[0];
        end
    end

    assign o_fall = clk_prev_q & ~w_filt[0];
    assign o_data = w_filt[1];

endmodule : ps2_line_filter
`default_nettype wire

// File: rtl/ps2_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_rx
// Purpose  : PS/2 device-to-host frame receiver. Collects start, 8 data bits
//            (LSB first), parity and stop, then presents the scan-code byte.
//            A stalled frame is abandoned after TIMEOUT_CYCLES without a
//            PS/2 clock edge.
// Ports    : i_clk      system clock (rising edge)
//            i_rst_n    asynchronous active-low reset
//            i_ps2_clk  raw PS/2 clock pin
//            i_ps2_data raw PS/2 data pin
//            o_data     last accepted byte ([3:0] and [7:4] drive one
//                       seven-segment digit each)
//            o_valid    one-cycle pulse: o_data was updated
//            o_err      one-cycle pulse: frame rejected or timed out
//            o_busy     high while a frame is in progress
// Build    : define PS2_RX_PARITY_CHECK_EN to reject frames with bad odd
//            parity; otherwise the parity bit is received and ignored.
// Revision : 1.0  initial release
// ============================================================================
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV_FILTER = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_ps2_clk,
    input  logic                i_ps2_data,
    output logic [c_DATA_W-1:0] o_data,
    output logic                o_valid,
    output logic                o_err,
    output logic                o_busy
);

    localparam int               c_TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
    // Index of the last data bit: frame minus start, parity, stop, minus one.
    localparam logic [2:0]       c_BIT_LAST = 3'(c_FRAME_LEN - 4);

    logic w_fall;
    logic w_bit;

    ps2_state_e          state_q,   state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [c_DATA_W-1:0] shift_q,   shift_d;
    logic [c_DATA_W-1:0] data_q,    data_d;
    logic                valid_q,   valid_d;
    logic                err_q,     err_d;
    logic [c_TO_W-1:0]   to_cnt_q,  to_cnt_d;
    logic                w_parity_ok;

    ps2_line_filter #(
        .CLK_DIV_FILTER (CLK_DIV_FILTER)
    ) u_line_filter (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_ps2_clk  (i_ps2_clk),
        .i_ps2_data (i_ps2_data),
        .o_data     (w_bit),
        .o_fall     (w_fall)
    );

`ifdef PS2_RX_PARITY_CHECK_EN
    logic parity_q, parity_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    always_comb begin
        parity_d = parity_q;
        if (w_fall && (state_q == ST_PARITY)) begin
            parity_d = w_bit;
        end
    end

    // Odd parity across data and parity bit.
    assign w_parity_ok = ^{shift_q, parity_q};
`else
    // The parity bit is clocked through the PARITY state and dropped.
    assign w_parity_ok = 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        to_cnt_d  = to_cnt_q;

        if (w_fall) begin
            // An edge always restarts the stall timer, even if it coincides
            // with the timer expiring.
            to_cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!w_bit) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {w_bit, shift_q[c_DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == c_BIT_LAST) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (w_bit && w_parity_ok) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (to_cnt_q == c_TO_LAST) begin
                state_d   = ST_IDLE;
                err_d     = 1'b1;
                to_cnt_d  = '0;
                shift_d   = '0;
                bit_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_err   = err_q;
    assign o_busy  = (state_q != ST_IDLE);

endmodule : ps2_rx
`default_nettype wire

// File: tb/tb_ps2_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ps2_rx
// Purpose  : Self-checking bench for ps2_rx. Frames come from a vector table
//            plus hand-written sequences for glitch, stall and mid-frame
//            reset; expected pulses are queued when a frame is sent and
//            matched when o_valid/o_err fire.
// Revision : 1.0  initial release
// ============================================================================
module tb_ps2_rx;

    localparam int FILT = 8;
    localparam int TO   = 300;
    localparam int HALF = 20;   // i_clk cycles per PS/2 clock half-period
    localparam int GAP  = 60;   // idle cycles after each frame
`ifdef PS2_RX_PARITY_CHECK_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_err;
    logic       o_busy;

    ps2_rx #(
        .CLK_DIV_FILTER (FILT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_data (ps2_data),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_err      (o_err),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       stp;
        logic       exp_err;
    } vec_t;

    exp_t       sb[$];
    int         checks        = 0;
    int         errors        = 0;
    int         pulse_cnt     = 0;
    int         pulse_cyc     = -1;
    int         last_fall_cyc = 0;
    logic [7:0] last_good     = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && (o_valid || o_err)) begin
            exp_t e;
            pulse_cnt++;
            pulse_cyc = cyc;
            check("valid_err_exclusive", {31'b0, o_valid & o_err}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", {30'b0, o_valid, o_err}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", {31'b0, o_err}, {31'b0, e.is_err});
                check("pulse_data", {24'b0, o_data}, {24'b0, e.data});
            end
        end
    end

    task automatic expect_frame(input logic is_err, input logic [7:0] d);
        exp_t e;
        e.is_err = is_err;
        e.data   = is_err ? last_good : d;
        sb.push_back(e);
        if (!is_err) last_good = d;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(par);
        ps2_bit(stp);
        ps2_data = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic drain(input string name);
        check(name, sb.size(), 32'd0);
        sb.delete();
    endtask

    vec_t tbl[8];

    initial begin
        int snap;
        logic [7:0] stall_byte;

        tbl[0] = '{8'h1C, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{8'h1C, 1'b1, 1'b1, PAR_EN};
        tbl[2] = '{8'hF0, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{8'h1C, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{8'hA5, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{8'h00, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{8'hFF, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{8'h37, 1'b0, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data",  {24'b0, o_data}, 32'h00);
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_err",   {31'b0, o_err}, 32'd0);
        check("rst_busy",  {31'b0, o_busy}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Short low glitch on PS/2 clock with data low: must not start a frame
        ps2_data = 1'b0;
        repeat (15) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (o_busy) check("glitch_busy", {31'b0, o_busy}, 32'd0);
        end
        check("glitch_idle", {31'b0, o_busy}, 32'd0);
        check("glitch_no_pulse", pulse_cnt, 32'd0);
        ps2_data = 1'b1;
        repeat (15) @(negedge clk);

        // Table of whole frames
        for (int i = 0; i < 8; i++) begin
            expect_frame(tbl[i].exp_err, tbl[i].d);
            send_frame(tbl[i].d, tbl[i].par, tbl[i].stp);
            drain($sformatf("frame%0d_pulse_seen", i));
            check($sformatf("frame%0d_data_hold", i), {24'b0, o_data}, {24'b0, last_good});
            check($sformatf("frame%0d_idle", i), {31'b0, o_busy}, 32'd0);
        end

        // Stall after 4 data bits: timeout error exactly TO cycles after the
        // FSM sees the edge (pin fall + 2 sync + FILT filter + 1 edge stage).
        stall_byte = 8'h5A;
        expect_frame(1'b1, 8'h00);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(stall_byte[i]);
        check("stall_busy", {31'b0, o_busy}, 32'd1);
        snap = pulse_cnt;
        for (int i = 0; i < 2 * TO && pulse_cnt == snap; i++) @(negedge clk);
        if (pulse_cnt == snap) begin
            check("timeout_seen", 32'd0, 32'd1);
        end else begin
            check("timeout_latency", pulse_cyc - last_fall_cyc, FILT + 3 + TO);
        end
        @(negedge clk);
        check("timeout_idle", {31'b0, o_busy}, 32'd0);
        drain("timeout_pulse_seen");
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
        expect_frame(1'b0, 8'hF0);
        send_frame(8'hF0, 1'b1, 1'b1);
        drain("after_timeout_pulse_seen");

        // Reset in the middle of a frame
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        check("midrst_busy_before", {31'b0, o_busy}, 32'd1);
        snap = pulse_cnt;
        rst_n = 1'b0;
        #1;
        check("midrst_busy_now", {31'b0, o_busy}, 32'd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        last_good = 8'h00;
        check("midrst_data", {24'b0, o_data}, 32'h00);
        repeat (10) @(negedge clk);
        check("midrst_no_pulse", pulse_cnt, snap);
        expect_frame(1'b0, 8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1);
        drain("midrst_next_frame_seen");
        check("midrst_final_data", {24'b0, o_data}, 32'h1C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_ps2_rx
`default_nettype wire
